ps_serializer: RTL and testbench

Parallel-to-serial stage directly downstream of the final 2:1 byte-lane mux stage. It takes the byte stream (data_out_l2/valid_out_l2) and shifts it out MSB-first on a single serial line. After reset it sends COM_COUNT alignment symbols. It inserts IDLE symbols whenever no valid byte is offered at a symbol boundary. The upstream byte clock is sclk divided by 8 and edge-aligned to the byte_req edge, so all transfers are sampled on sclk only.

---
 rtl/ps_phy_pkg.sv | 24 ++
 rtl/ps_serializer_if.sv | 40 ++++
 rtl/ps_serializer_shift8.sv | 37 +++
 rtl/ps_serializer.sv | 120 ++++++++++++
 tb/tb_ps_serializer.sv | 208 ++++++++++++++++++++
 5 files changed

// File: rtl/ps_phy_pkg.sv
// ----------------------------------------------------------------------------
// ps_phy_pkg
// Shared definitions for the serial PHY path: the symbol width, the control
// symbol codes and the serializer state type. The future deserializer/aligner
// imports the same package so both ends agree on COM/IDLE encodings.
// ----------------------------------------------------------------------------
package ps_phy_pkg;

  // Width of one line symbol in bits.
  localparam int unsigned PS_SYM_W = 8;

  // Alignment symbol sent after reset.
  localparam logic [PS_SYM_W-1:0] PS_COM_SYM = 8'hBC;

  // Filler symbol sent when no data byte is offered at a symbol boundary.
  localparam logic [PS_SYM_W-1:0] PS_IDLE_SYM = 8'h7C;

  // Serializer mode: alignment burst after reset, then data/idle forever.
  typedef enum logic [0:0] {
    ST_COM    = 1'b0,
    ST_ACTIVE = 1'b1
  } ps_state_e;

endpackage

// File: rtl/ps_serializer_if.sv
// ----------------------------------------------------------------------------
// ps_serializer_if
// Byte-in / bit-out bundle of the parallel-to-serial stage.
//   valid_in  : upstream byte is valid (sampled only on load edges)
//   data_in   : upstream byte
//   byte_req  : serializer will sample data_in/valid_in on the next edge
//   data_out  : serial bit, MSB first
//   frame     : high while a symbol's MSB is on data_out
//   valid_out : high for all 8 bits of a symbol that carries a data byte
// Modports: master = upstream byte source, slave = serializer.
// ----------------------------------------------------------------------------
interface ps_serializer_if;
  import ps_phy_pkg::*;

  logic                valid_in;
  logic [PS_SYM_W-1:0] data_in;
  logic                byte_req;
  logic                data_out;
  logic                frame;
  logic                valid_out;

  modport master (
    output valid_in,
    output data_in,
    input  byte_req,
    input  data_out,
    input  frame,
    input  valid_out
  );

  modport slave (
    input  valid_in,
    input  data_in,
    output byte_req,
    output data_out,
    output frame,
    output valid_out
  );

endinterface

// File: rtl/ps_serializer_shift8.sv
// ----------------------------------------------------------------------------
// ps_shift8
// 8-bit parallel-in / serial-out register, MSB first, zero fill.
//   clk   : shift clock (rising edge)
//   rst_n : asynchronous active-low reset, clears the register
//   load  : capture din on this edge (has priority over shift)
//   shift : shift left by one with 0 fill on this edge
//   din   : parallel symbol
//   msb   : current serial bit (register bit 7)
// ----------------------------------------------------------------------------
module ps_shift8 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic       shift,
  input  logic [7:0] din,
  output logic       msb
);

  logic [7:0] shift_r;

  // Symbol register: parallel load wins over shift, otherwise hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_r <= 8'h00;
    end else if (load) begin
      shift_r <= din;
    end else if (shift) begin
      shift_r <= {shift_r[6:0], 1'b0};
    end else begin
      shift_r <= shift_r;
    end
  end

  assign msb = shift_r[7];

endmodule

// File: rtl/ps_serializer.sv
// ----------------------------------------------------------------------------
// ps_serializer
// Parallel-to-serial stage fed by the final 2:1 byte-lane mux. After reset it
// emits COM_COUNT alignment symbols, then one symbol per 8 sclk cycles: the
// offered data byte when valid_in is high at the load edge, IDLE otherwise.
//   sclk    : serial bit clock, all logic on the rising edge
//   reset_L : asynchronous active-low reset
//   bus     : ps_serializer_if.slave (valid_in, data_in, byte_req,
//             data_out, frame, valid_out)
// ----------------------------------------------------------------------------
module ps_serializer
  import ps_phy_pkg::*;
#(
  parameter int unsigned         DATA_W    = PS_SYM_W,
  parameter logic [DATA_W-1:0]   COM_SYM   = PS_COM_SYM,
  parameter logic [DATA_W-1:0]   IDLE_SYM  = PS_IDLE_SYM,
  parameter int unsigned         COM_COUNT = 4
) (
  input  logic          sclk,
  input  logic          reset_L,
  ps_serializer_if.slave bus
);

  localparam int unsigned       BIT_W    = $clog2(DATA_W);
  localparam logic [BIT_W-1:0]  LAST_BIT = BIT_W'(DATA_W - 1);
  localparam int unsigned       CNT_W    = $clog2(COM_COUNT + 1);
  // com_cnt value just before the final COM is loaded.
  localparam logic [CNT_W-1:0]  COM_LAST = CNT_W'(COM_COUNT - 1);

  ps_state_e          state_r;
  logic [BIT_W-1:0]   bit_cnt_r;
  logic [CNT_W-1:0]   com_cnt_r;
  logic               valid_r;
  logic               frame_r;

  logic               load_s;
  logic [DATA_W-1:0]  sym_s;
  logic               sym_valid_s;
  logic               data_bit_s;

  assign load_s = (bit_cnt_r == LAST_BIT);

  // Next symbol selection: COM during alignment, data or IDLE afterwards.
  always_comb begin
    sym_s       = COM_SYM;
    sym_valid_s = 1'b0;
    case (state_r)
      ST_COM: begin
        sym_s       = COM_SYM;
        sym_valid_s = 1'b0;
      end
      ST_ACTIVE: begin
        if (bus.valid_in) begin
          sym_s       = bus.data_in;
          sym_valid_s = 1'b1;
        end else begin
          sym_s       = IDLE_SYM;
          sym_valid_s = 1'b0;
        end
      end
      default: begin
        sym_s       = COM_SYM;
        sym_valid_s = 1'b0;
      end
    endcase
  end

  // Bit counter, COM counter, mode FSM and per-symbol output flags.
  always_ff @(posedge sclk or negedge reset_L) begin
    if (!reset_L) begin
      state_r   <= ST_COM;
      bit_cnt_r <= LAST_BIT;
      com_cnt_r <= {CNT_W{1'b0}};
      valid_r   <= 1'b0;
      frame_r   <= 1'b0;
    end else begin
      bit_cnt_r <= bit_cnt_r + BIT_W'(1);
      // frame follows the load edge, i.e. it is high exactly when bit_cnt==0.
      frame_r   <= load_s;
      if (load_s) begin
        valid_r <= sym_valid_s;
        case (state_r)
          ST_COM: begin
            com_cnt_r <= com_cnt_r + CNT_W'(1);
            if (com_cnt_r == COM_LAST) begin
              state_r <= ST_ACTIVE;
            end else begin
              state_r <= ST_COM;
            end
          end
          ST_ACTIVE: begin
            state_r <= ST_ACTIVE;
          end
          default: begin
            state_r <= ST_COM;
          end
        endcase
      end else begin
        valid_r <= valid_r;
      end
    end
  end

  ps_shift8 u_shift (
    .clk   (sclk),
    .rst_n (reset_L),
    .load  (load_s),
    .shift (~load_s),
    .din   (sym_s),
    .msb   (data_bit_s)
  );

  // byte_req is a decode of registered state so upstream sees it one full
  // cycle ahead of the sampling edge.
  assign bus.byte_req  = (state_r == ST_ACTIVE) && load_s;
  assign bus.data_out  = data_bit_s;
  assign bus.frame     = frame_r;
  assign bus.valid_out = valid_r;

endmodule

// File: tb/tb_ps_serializer.sv
`timescale 1ns/1ps
module tb_ps_serializer;
  import ps_phy_pkg::*;

  localparam int NS = 512;

  logic       sclk = 1'b0;
  logic [1:0] rst_l;

  ps_serializer_if bus0();
  ps_serializer_if bus1();

  always #5 sclk = ~sclk;

  // dut0: COM_COUNT=4, dut1: COM_COUNT=1
  ps_serializer #(.COM_COUNT(4)) dut0 (.sclk(sclk), .reset_L(rst_l[0]), .bus(bus0));
  ps_serializer #(.COM_COUNT(1)) dut1 (.sclk(sclk), .reset_L(rst_l[1]), .bus(bus1));

  // reference model: list of symbols (value, carries data) per DUT
  logic [7:0] sym_d [2][NS];
  bit         sym_v [2][NS];
  int         cyc   [2];
  bit         in_rst[2];
  bit         rand1;
  int         n_vec = 0;
  int         n_bad = 0;

  typedef struct {
    logic       v;
    logic [7:0] d;
    bit         noise;
    logic [7:0] exp_sym;
    logic       exp_v;
  } vec_t;
  vec_t tbl[9];

  function automatic int cc_of(int i);
    return (i == 0) ? 4 : 1;
  endfunction

  function automatic logic [3:0] dut_out(int i);
    if (i == 0) return {bus0.data_out, bus0.frame, bus0.valid_out, bus0.byte_req};
    else        return {bus1.data_out, bus1.frame, bus1.valid_out, bus1.byte_req};
  endfunction

  function automatic logic [8:0] dut_in(int i);
    if (i == 0) return {bus0.valid_in, bus0.data_in};
    else        return {bus1.valid_in, bus1.data_in};
  endfunction

  task automatic set_in(int i, logic v, logic [7:0] d);
    if (i == 0) begin bus0.valid_in = v; bus0.data_in = d; end
    else        begin bus1.valid_in = v; bus1.data_in = d; end
  endtask

  // Expected {data_out, frame, valid_out, byte_req} at the current cycle.
  // Cycle c>=1 shows bit (c-1)%8 of symbol (c-1)/8; byte_req precedes every
  // load that takes upstream data.
  function automatic logic [3:0] model_out(int i);
    int c, s, b;
    c = cyc[i];
    if (in_rst[i] || c == 0) return 4'b0000;
    s = (c - 1) / 8;
    b = (c - 1) % 8;
    return {sym_d[i][s][7-b], (b == 0), sym_v[i][s], ((c % 8) == 0) && ((c / 8) >= cc_of(i))};
  endfunction

  task automatic check(string name, int i, logic [31:0] got, logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s dut%0d cyc=%0d got=%h expected=%h", name, i, cyc[i], got, exp);
    end
  endtask

  // One sclk cycle: record the symbol the model expects to be loaded, then
  // advance and compare both DUTs against the model.
  task automatic tick();
    int s;
    logic [8:0] vi;
    for (int i = 0; i < 2; i++) begin
      if (!in_rst[i] && (cyc[i] % 8) == 0) begin
        s  = cyc[i] / 8;
        vi = dut_in(i);
        if (s < NS) begin
          if (s < cc_of(i)) begin
            sym_d[i][s] = PS_COM_SYM; sym_v[i][s] = 1'b0;
          end else if (vi[8]) begin
            sym_d[i][s] = vi[7:0];    sym_v[i][s] = 1'b1;
          end else begin
            sym_d[i][s] = PS_IDLE_SYM; sym_v[i][s] = 1'b0;
          end
        end
      end
    end
    @(posedge sclk);
    #2;
    for (int i = 0; i < 2; i++) begin
      if (!in_rst[i]) cyc[i]++;
      check("cycle", i, 32'(dut_out(i)), 32'(model_out(i)));
    end
    if (rand1) set_in(1, 1'($urandom_range(0, 1)), 8'($urandom));
  endtask

  logic [31:0] got32, v32;
  logic [15:0] got16, v16;
  logic [7:0]  gb, gv, gf;
  int          br_early;

  initial begin
    tbl[0] = '{1'b1, 8'hA5, 1'b0, 8'hA5, 1'b1};
    tbl[1] = '{1'b1, 8'h01, 1'b0, 8'h01, 1'b1};
    tbl[2] = '{1'b1, 8'hFF, 1'b0, 8'hFF, 1'b1};
    tbl[3] = '{1'b1, 8'h80, 1'b0, 8'h80, 1'b1};
    tbl[4] = '{1'b0, 8'h00, 1'b1, 8'h7C, 1'b0};
    tbl[5] = '{1'b0, 8'h00, 1'b1, 8'h7C, 1'b0};
    tbl[6] = '{1'b1, 8'hBC, 1'b0, 8'hBC, 1'b1};
    tbl[7] = '{1'b1, 8'h7C, 1'b0, 8'h7C, 1'b1};
    tbl[8] = '{1'b0, 8'h5A, 1'b0, 8'h7C, 1'b0};

    rand1 = 1'b0;
    rst_l = 2'b00;
    in_rst[0] = 1'b1; in_rst[1] = 1'b1;
    cyc[0] = 0; cyc[1] = 0;
    set_in(0, 1'b0, 8'h00);
    set_in(1, 1'b0, 8'h00);
    #1;
    check("reset_out", 0, 32'(dut_out(0)), 32'h0);
    check("reset_out", 1, 32'(dut_out(1)), 32'h0);
    repeat (3) tick();
    rst_l = 2'b11;
    in_rst[0] = 1'b0; in_rst[1] = 1'b0;

    // COM burst on dut0; dut1 gets 8'hBC as data at its first byte_req
    got32 = '0; got16 = '0; v16 = '0; br_early = 0;
    for (int k = 1; k <= 32; k++) begin
      if (cyc[1] == 8) set_in(1, 1'b1, 8'hBC);
      else             set_in(1, 1'b0, 8'h00);
      tick();
      got32 = {got32[30:0], bus0.data_out};
      if (k < 32 && bus0.byte_req) br_early++;
      if (k <= 16) begin
        got16 = {got16[14:0], bus1.data_out};
        v16   = {v16[14:0], bus1.valid_out};
      end
    end
    check("com_bits", 0, got32, 32'hBCBCBCBC);
    check("byte_req_early", 0, 32'(br_early), 32'd0);
    check("byte_req_c32", 0, 32'(bus0.byte_req), 32'd1);
    check("cc1_bits", 1, 32'(got16), 32'h0000BCBC);
    check("cc1_valid", 1, 32'(v16), 32'h000000FF);
    rand1 = 1'b1;

    // table: one record per byte_req slot, starting at cycle 32
    for (int t = 0; t < 9; t++) begin
      set_in(0, tbl[t].v, tbl[t].d);
      gb = '0; gv = '0; gf = '0;
      for (int k = 0; k < 8; k++) begin
        tick();
        gb = {gb[6:0], bus0.data_out};
        gv = {gv[6:0], bus0.valid_out};
        gf = {gf[6:0], bus0.frame};
        if (k < 7 && tbl[t].noise) set_in(0, ~k[0], 8'h3C);
      end
      check("tbl_sym", 0, 32'(gb), 32'(tbl[t].exp_sym));
      check("tbl_valid", 0, 32'(gv), 32'({8{tbl[t].exp_v}}));
      check("tbl_frame", 0, 32'(gf), 32'h80);
    end

    // randomized traffic against the model
    for (int k = 0; k < 800; k++) begin
      set_in(0, 1'($urandom_range(0, 1)), 8'($urandom));
      tick();
    end

    // reset in the middle of a data byte (bit_cnt==3)
    for (int k = 0; k < 8 && (cyc[0] % 8) != 0; k++) tick();
    set_in(0, 1'b1, 8'hFF);
    repeat (4) tick();
    check("pre_rst_bit", 0, 32'({bus0.data_out, bus0.valid_out}), 32'h3);
    #2;
    rst_l[0] = 1'b0;
    in_rst[0] = 1'b1;
    #1;
    check("async_rst", 0, 32'(dut_out(0)), 32'h0);
    repeat (2) tick();
    rst_l[0] = 1'b1;
    in_rst[0] = 1'b0;
    cyc[0] = 0;
    got32 = '0; v32 = '0;
    for (int k = 0; k < 32; k++) begin
      set_in(0, 1'b1, 8'hFF);
      tick();
      got32 = {got32[30:0], bus0.data_out};
      v32   = {v32[30:0], bus0.valid_out};
    end
    check("com_restart", 0, got32, 32'hBCBCBCBC);
    check("com_restart_valid", 0, v32, 32'h0);
    for (int k = 0; k < 120; k++) begin
      set_in(0, 1'($urandom_range(0, 1)), 8'($urandom));
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
